wb_trace_buf: RTL and testbench



---
 rtl/wb_trace_pkg.sv | 27 ++
 rtl/wb_trace_fifo.sv | 74 +++++++
 rtl/wb_trace_buf.sv | 135 +++++++++++++
 tb/tb_wb_trace_buf.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace buffer: FSM states, record layout and
// the drop-counter width.
package wb_trace_pkg;

    localparam int unsigned RD_W     = 5;
    localparam int unsigned DROP_W   = 16;
    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_TS_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // One trace record at the default XLEN/TS_W geometry.
    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [DEF_XLEN-1:0] data;
        logic [DEF_TS_W-1:0] ts;
    } wb_rec_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through record FIFO with optional overwrite of the oldest
// entry when a push meets a full FIFO.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     wrap,
    input  logic                     ready,
    input  logic [W-1:0]             wr_data,
    output logic                     valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     pop_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          wr_en;
    logic          ovw;

    assign full_c  = (count == CW'(DEPTH));
    assign pop_c   = valid && ready;
    assign wr_en   = push && (!full_c || pop_c || wrap);
    assign ovw     = push && full_c && !pop_c && wrap;
    // Gate the head so reset/empty present zeros rather than stale storage.
    assign rd_data = valid ? mem[head] : {W{1'b0}};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= 1'b0;
        end else begin
            if (wr_en) begin
                tail <= tail + PW'(1);
            end
            if (pop_c || ovw) begin
                head <= head + PW'(1);
            end
            // Push+pop and overwrite-while-full both leave count unchanged.
            if (push && !pop_c && !full_c) begin
                count <= count + CW'(1);
                valid <= 1'b1;
            end else if (pop_c && !push) begin
                count <= count - CW'(1);
                valid <= (count != CW'(1));
            end
        end
    end

endmodule

// File: rtl/wb_trace_buf.sv
// Register-writeback trace buffer: filters CPU writebacks by rd and queues them
// for draining. Define WB_TRACE_TS_EN to store a per-record cycle timestamp.
module wb_trace_buf
    import wb_trace_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   wrap_mode,
    input  logic [31:0]            rd_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_data,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   capturing,
    output logic [DROP_W-1:0]      dropped
);

`ifdef WB_TRACE_TS_EN
    localparam int unsigned REC_W = RD_W + XLEN + TS_W;
    logic [TS_W-1:0] ts;
`else
    localparam int unsigned REC_W = RD_W + XLEN;
`endif

    state_t           state;
    logic             wrap_q;
    logic             full_stop;
    logic             match_c;
    logic             accept_c;
    logic             lost_c;
    logic             stop_full_c;
    logic             full_c;
    logic             pop_c;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;

    // Writebacks in the arm cycle are never captured.
    assign match_c     = wb_en && (wb_rd != RD_W'(0)) && rd_mask[wb_rd];
    assign accept_c    = (state == S_CAPTURE) && !arm && match_c;
    assign stop_full_c = accept_c && full_c && !pop_c && !wrap_q;
    // After a full-stop, matching writebacks that still find no room are lost too.
    assign lost_c      = match_c && !arm && full_c && !pop_c &&
                         ((state == S_CAPTURE) || ((state == S_DONE) && full_stop));

`ifdef WB_TRACE_TS_EN
    assign wr_rec   = {wb_rd, wb_data, ts};
    assign out_rd   = rd_rec[REC_W-1 -: RD_W];
    assign out_data = rd_rec[XLEN+TS_W-1 -: XLEN];
    assign out_ts   = rd_rec[TS_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else if (arm) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end
`else
    assign wr_rec   = {wb_rd, wb_data};
    assign out_rd   = rd_rec[REC_W-1 -: RD_W];
    assign out_data = rd_rec[XLEN-1:0];
    assign out_ts   = {TS_W{1'b0}};
`endif

    wb_trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (arm),
        .push    (accept_c),
        .wrap    (wrap_q),
        .ready   (out_ready),
        .wr_data (wr_rec),
        .valid   (out_valid),
        .rd_data (rd_rec),
        .count   (count),
        .full_c  (full_c),
        .pop_c   (pop_c)
    );

    // Capture FSM; arm restarts from any state and beats a simultaneous stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            capturing <= 1'b0;
            wrap_q    <= 1'b0;
            full_stop <= 1'b0;
        end else if (arm) begin
            state     <= S_CAPTURE;
            capturing <= 1'b1;
            wrap_q    <= wrap_mode;
            full_stop <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    if (stop_full_c) begin
                        state     <= S_DONE;
                        capturing <= 1'b0;
                        full_stop <= 1'b1;
                    end else if (stop) begin
                        state     <= S_DONE;
                        capturing <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped <= '0;
        end else if (arm) begin
            dropped <= '0;
        end else if (lost_c) begin
            dropped <= sat_inc(dropped);
        end
    end

endmodule

// File: tb/tb_wb_trace_buf.sv
// Randomized scoreboard bench for wb_trace_buf (DEPTH=4) against a queue-based
// reference model; a negedge monitor checks every drained record.
module tb_wb_trace_buf;
    import wb_trace_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 16;
`ifdef WB_TRACE_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        arm;
    logic        stop;
    logic        wrap_mode;
    logic [31:0] rd_mask;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [2:0]  count;
    logic        capturing;
    logic [15:0] dropped;

    always #5 clk = ~clk;

    wb_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .arm       (arm),
        .stop      (stop),
        .wrap_mode (wrap_mode),
        .rd_mask   (rd_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .capturing (capturing),
        .dropped   (dropped)
    );

    wb_rec_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_cap;
    bit          m_fullstop;
    bit          m_wrap;
    int          m_count;
    int          m_drop;
    logic [15:0] m_ts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cap      = 1'b0;
        m_fullstop = 1'b0;
        m_wrap     = 1'b0;
        m_count    = 0;
        m_drop     = 0;
        m_ts       = '0;
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        bit      match;
        bit      pop;
        int      n;
        wb_rec_t r;
        match = wb_en && (wb_rd != 5'd0) && rd_mask[wb_rd];
        if (arm) begin
            exp_q.delete();
            m_count    = 0;
            m_drop     = 0;
            m_ts       = '0;
            m_wrap     = wrap_mode;
            m_cap      = 1'b1;
            m_fullstop = 1'b0;
            return;
        end
        n       = exp_q.size();
        pop     = out_ready && (n > 0);
        r.rd    = wb_rd;
        r.data  = wb_data;
        r.ts    = TS_EN ? m_ts : 16'd0;
        if (m_cap && match) begin
            if (n < DEPTH || pop) begin
                exp_q.push_back(r);
            end else begin
                if (m_drop < 65535) m_drop++;
                if (m_wrap) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(r);
                end else begin
                    m_cap      = 1'b0;
                    m_fullstop = 1'b1;
                end
            end
        end else if (m_fullstop && match && n == DEPTH && !pop) begin
            if (m_drop < 65535) m_drop++;
        end
        m_count = exp_q.size() - (pop ? 1 : 0);
        if (stop) m_cap = 1'b0;
        m_ts = m_ts + 16'd1;
    endtask

    task automatic check_status();
        chk("count", 64'(count), 64'(m_count));
        chk("dropped", 64'(dropped), 64'(m_drop));
        chk("capturing", 64'(capturing), 64'(m_cap));
        chk("out_valid", 64'(out_valid), 64'(m_count != 0));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_arm(input logic w, input logic [31:0] mask);
        arm       = 1'b1;
        wrap_mode = w;
        rd_mask   = mask;
        tick();
        arm       = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle(DEPTH + 2);
        out_ready = 1'b0;
        chk("drained_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every handshake pops and compares one expected record.
    always @(negedge clk) begin
        wb_rec_t e;
        if (!rst && !arm && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got rd %0d data %0h expected no record", out_rd, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_rd", 64'(out_rd), 64'(e.rd));
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_ts", 64'(out_ts), 64'(e.ts));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        arm       = 1'b0;
        stop      = 1'b0;
        wrap_mode = 1'b0;
        rd_mask   = '1;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ts", 64'(out_ts), 64'd0);
        check_status();
        rst = 1'b0;

        // Two records with timestamps 3 and 4.
        do_arm(1'b0, '1);
        idle(3);
        do_wb(5'd1, 32'h7fff_ffff);
        do_wb(5'd2, 32'h8000_0000);
        chk("t1_head_data", 64'(out_data), 64'h7fff_ffff);
        chk("t1_head_ts", 64'(out_ts), TS_EN ? 64'd3 : 64'd0);
        drain();

        // x0 and masked-off x5 are never captured.
        do_arm(1'b0, ~32'h0000_0020);
        do_wb(5'd0, 32'h1234);
        do_wb(5'd5, 32'h5678);
        idle(1);
        chk("t2_count", 64'(count), 64'd0);
        chk("t2_dropped", 64'(dropped), 64'd0);

        // Stop mode overflow keeps the first DEPTH records.
        do_arm(1'b0, '1);
        for (int i = 1; i <= 6; i++) do_wb(5'(i), 32'(i * 17));
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_dropped", 64'(dropped), 64'd2);
        chk("t3_capturing", 64'(capturing), 64'd0);
        chk("t3_head", 64'(out_data), 64'd17);
        drain();

        // Wrap mode keeps the newest DEPTH records.
        do_arm(1'b1, '1);
        for (int i = 1; i <= 6; i++) do_wb(5'd3, 32'(i));
        chk("t4_dropped", 64'(dropped), 64'd2);
        chk("t4_head", 64'(out_data), 64'd3);
        drain();

        // Push and pop together on a full FIFO.
        do_arm(1'b0, '1);
        for (int i = 1; i <= 4; i++) do_wb(5'd7, 32'(100 + i));
        out_ready = 1'b1;
        for (int i = 5; i <= 7; i++) do_wb(5'd7, 32'(100 + i));
        out_ready = 1'b0;
        chk("t5_count", 64'(count), 64'd4);
        chk("t5_dropped", 64'(dropped), 64'd0);
        chk("t5_head", 64'(out_data), 64'd104);
        drain();

        // Asynchronous reset mid-capture.
        do_arm(1'b0, '1);
        for (int i = 1; i <= 3; i++) do_wb(5'd9, 32'(i));
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_capturing", 64'(capturing), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(0, 39) == 0);
            if (arm) begin
                wrap_mode = 1'($urandom_range(0, 1));
                rd_mask   = ($urandom_range(0, 1) == 1) ? 32'hffff_ffff : 32'($urandom);
            end
            stop      = ($urandom_range(0, 59) == 0);
            wb_en     = ($urandom_range(0, 9) < 6);
            wb_rd     = 5'($urandom_range(0, 31));
            wb_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        arm   = 1'b0;
        stop  = 1'b0;
        wb_en = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
